// File: rtl/multicycle_ctrl.sv
// Multi-cycle ARM control FSM: sequences fetch/decode/execute/memory/writeback over a shared ALU and memory.
// Outputs are combinational from state and inputs; MemReady=0 stalls FETCH/MEMRD/MEMWR with enables held.
module multicycle_ctrl (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr,
  input  logic        CondEx,
  input  logic        MemReady,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic        RegW,
  output logic        MemW,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUControl,
  output logic [1:0]  FlagW,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  logic [3:0] state_q;
  state_t     state_d;

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic       rd_pc;
  logic       unused_instr;

  assign op           = Instr[27:26];
  assign funct        = Instr[25:20];
  assign cmd          = funct[4:1];
  assign rd_pc        = (Instr[15:12] == 4'hF);
  assign unused_instr = ^{Instr[31:28], Instr[19:16], Instr[11:0]};

  logic [1:0] dp_alu;
  logic [1:0] dp_flag;
  logic       nowrite;

  // Data-processing decode; funct[0] is the S bit here.
  always_comb begin
    dp_alu  = 2'b00;
    dp_flag = 2'b00;
    nowrite = 1'b0;
    case (cmd)
      4'b0100: dp_flag = funct[0] ? 2'b11 : 2'b00;
      4'b0010: begin dp_alu = 2'b01; dp_flag = funct[0] ? 2'b11 : 2'b00; end
      4'b0000: begin dp_alu = 2'b10; dp_flag = funct[0] ? 2'b10 : 2'b00; end
      4'b1100: begin dp_alu = 2'b11; dp_flag = funct[0] ? 2'b10 : 2'b00; end
      4'b1010: begin
        nowrite = 1'b1;
        if (funct[0]) begin dp_alu = 2'b01; dp_flag = 2'b11; end
      end
      4'b1011: begin
        nowrite = 1'b1;
        if (funct[0]) dp_flag = 2'b11;
      end
      default: nowrite = 1'b1;
    endcase
  end

  always_comb begin
    case (op)
      2'b01:   begin ImmSrc = 2'b01; RegSrc = 2'b10; end
      2'b10:   begin ImmSrc = 2'b10; RegSrc = 2'b01; end
      default: begin ImmSrc = 2'b00; RegSrc = 2'b00; end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  logic       irwrite, pcwrite, regw, memw;
  logic [1:0] flagw;

  always_comb begin
    state_d    = S_FETCH;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    regw       = 1'b0;
    memw       = 1'b0;
    flagw      = 2'b00;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 2'b00;
    case (state_q)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        irwrite   = MemReady;
        pcwrite   = MemReady;
        state_d   = MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (op)
          2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB    = 2'b01;
        ALUControl = funct[3] ? 2'b00 : 2'b01;
        state_d    = funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = MemReady ? S_MEMWB : S_MEMRD;
      end
      S_MEMWR: begin
        AdrSrc  = 1'b1;
        memw    = CondEx;
        state_d = MemReady ? S_FETCH : S_MEMWR;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        regw      = CondEx;
        pcwrite   = CondEx & rd_pc;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcB    = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        ALUControl = dp_alu;
        flagw      = dp_flag & {2{CondEx}};
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        regw    = CondEx & ~nowrite;
        pcwrite = CondEx & ~nowrite & rd_pc;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pcwrite   = CondEx;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset suppresses every write so an interrupted access leaves no partial effect.
  assign IRWrite = irwrite & ~RESET;
  assign PCWrite = pcwrite & ~RESET;
  assign RegW    = regw & ~RESET;
  assign MemW    = memw & ~RESET;
  assign FlagW   = flagw & {2{~RESET}};
  assign State   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed vector table, hand-written corner sequences, randomized instructions vs model.
module tb_multicycle_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] Instr;
  logic        CondEx;
  logic        MemReady;
  logic        IRWrite, PCWrite, AdrSrc, ALUSrcA, RegW, MemW;
  logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, FlagW;
  logic [3:0]  State;

  multicycle_ctrl dut (
    .CLK(CLK), .RESET(RESET), .Instr(Instr), .CondEx(CondEx), .MemReady(MemReady),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .RegW(RegW), .MemW(MemW),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .FlagW(FlagW),
    .State(State)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        condex;
    int          cycles, regw, pcw, memw, flagw, alu;
  } vec_t;

  vec_t vecs [15];

  int n_chk = 0;
  int n_fail = 0;
  int hold3 = 0;

  int st_q [$];
  int rdy_q [$];
  int o_regw, o_pcw, o_memw, o_flag, o_alu, o_imm, o_regw_st;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One instruction from FETCH back to FETCH, recording what the DUT did each cycle.
  // mode 0: memory always ready (except hold3 stalls in MEMRD); mode 1: random ready.
  task automatic exec_instr(input logic [31:0] ins, input logic cx, input int mode);
    int st;
    int guard;
    bit done;
    st_q.delete();
    rdy_q.delete();
    o_regw = 0; o_pcw = 0; o_memw = 0; o_flag = 0; o_alu = 0; o_imm = 0; o_regw_st = -1;
    Instr = ins;
    CondEx = cx;
    done = 1'b0;
    guard = 0;
    while (!done) begin
      @(negedge CLK);
      st = int'(State);
      if (st == 3 && hold3 > 0) begin
        MemReady = 1'b0;
        hold3--;
      end else if (mode == 1) MemReady = ($urandom_range(0, 2) != 0);
      else MemReady = 1'b1;
      #1;
      st_q.push_back(st);
      rdy_q.push_back(int'(MemReady));
      if (RegW) begin o_regw++; o_regw_st = st; end
      if (PCWrite) o_pcw++;
      if (MemW) o_memw++;
      o_flag = o_flag | int'(FlagW);
      if (st == 2 || st == 6 || st == 7) o_alu = int'(ALUControl);
      if (st != 0) o_imm = int'(ImmSrc);
      @(posedge CLK);
      #1;
      guard++;
      if (State == 4'd0 && st != 0) done = 1'b1;
      else if (guard >= 60) begin
        n_chk++;
        n_fail++;
        $display("FAIL timeout: instr %08h still in state %0d after %0d cycles, required return to 0", ins, State, guard);
        done = 1'b1;
      end
    end
  endtask

  // Reference: instruction semantics in terms of state path and per-instruction effects.
  task automatic check_model(input logic [31:0] ins, input logic cx);
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic s, l, u, rd15;
    int path [$];
    int exp_q [$];
    int c, r, e_alu, e_flag, e_regw, e_pcw, e_memw, e_imm, bad;
    bit writes, adv;
    op = ins[27:26]; funct = ins[25:20]; cmd = funct[4:1];
    s = funct[0]; l = funct[0]; u = funct[3]; rd15 = (ins[15:12] == 4'hF);
    e_alu = 0; e_flag = 0; writes = 1'b0;
    case (cmd)
      4'h4: begin e_alu = 0; e_flag = s ? 3 : 0; writes = 1'b1; end
      4'h2: begin e_alu = 1; e_flag = s ? 3 : 0; writes = 1'b1; end
      4'h0: begin e_alu = 2; e_flag = s ? 2 : 0; writes = 1'b1; end
      4'hC: begin e_alu = 3; e_flag = s ? 2 : 0; writes = 1'b1; end
      4'hA: begin e_alu = s ? 1 : 0; e_flag = s ? 3 : 0; end
      4'hB: begin e_alu = 0; e_flag = s ? 3 : 0; end
      default: begin e_alu = 0; e_flag = 0; end
    endcase
    path.push_back(0);
    path.push_back(1);
    e_regw = 0; e_pcw = 1; e_memw = 0; e_imm = 0;
    case (op)
      2'b00: begin
        path.push_back(funct[5] ? 7 : 6);
        path.push_back(8);
        e_regw = (cx && writes) ? 1 : 0;
        e_pcw += (cx && writes && rd15) ? 1 : 0;
        e_flag = cx ? e_flag : 0;
      end
      2'b01: begin
        path.push_back(2);
        path.push_back(l ? 3 : 5);
        if (l) path.push_back(4);
        e_alu = u ? 0 : 1;
        e_regw = (cx && l) ? 1 : 0;
        e_pcw += (cx && l && rd15) ? 1 : 0;
        e_imm = 1;
        e_flag = 0;
      end
      2'b10: begin
        path.push_back(9);
        e_pcw += cx ? 1 : 0;
        e_alu = 0; e_flag = 0; e_imm = 2;
      end
      default: begin e_alu = 0; e_flag = 0; end
    endcase
    c = 0;
    foreach (path[k]) begin
      adv = 1'b0;
      while (!adv && exp_q.size() < 100) begin
        exp_q.push_back(path[k]);
        r = (c < rdy_q.size()) ? rdy_q[c] : 1;
        c++;
        if (!((path[k] == 0 || path[k] == 3 || path[k] == 5) && r == 0)) adv = 1'b1;
        else if (path[k] == 5 && cx) e_memw++;
      end
      if (path[k] == 5 && cx) e_memw++;
    end
    bad = -1;
    foreach (exp_q[k])
      if (bad < 0 && (k >= st_q.size() || st_q[k] != exp_q[k])) bad = k;
    chk($sformatf("rnd_seq %08h first bad idx", ins), bad, -1);
    chk($sformatf("rnd_cycles %08h", ins), st_q.size(), exp_q.size());
    chk($sformatf("rnd_regw %08h", ins), o_regw, e_regw);
    chk($sformatf("rnd_pcw %08h", ins), o_pcw, e_pcw);
    chk($sformatf("rnd_memw %08h", ins), o_memw, e_memw);
    chk($sformatf("rnd_flagw %08h", ins), o_flag, e_flag);
    chk($sformatf("rnd_alu %08h", ins), o_alu, e_alu);
    chk($sformatf("rnd_imm %08h", ins), o_imm, e_imm);
  endtask

  initial begin
    logic [31:0] ins;
    logic        cx;
    logic [3:0]  cl [8];
    int          ldr_exp [7];

    //           name        instr         cx  cyc regw pcw memw flag alu
    vecs[0]  = '{"adds",     32'hE2921005, 1'b1, 4, 1, 1, 0, 3, 0};
    vecs[1]  = '{"adds_nc",  32'hE2921005, 1'b0, 4, 0, 1, 0, 0, 0};
    vecs[2]  = '{"ldr",      32'hE5143008, 1'b1, 5, 1, 1, 0, 0, 1};
    vecs[3]  = '{"ldr_pc",   32'hE514F008, 1'b1, 5, 1, 2, 0, 0, 1};
    vecs[4]  = '{"str_nc",   32'hE5843000, 1'b0, 4, 0, 1, 0, 0, 0};
    vecs[5]  = '{"str",      32'hE5843000, 1'b1, 4, 0, 1, 1, 0, 0};
    vecs[6]  = '{"cmp",      32'hE1500001, 1'b1, 4, 0, 1, 0, 3, 1};
    vecs[7]  = '{"mov_cls",  32'hE1A01002, 1'b1, 4, 0, 1, 0, 0, 0};
    vecs[8]  = '{"ands",     32'hE2110001, 1'b1, 4, 1, 1, 0, 2, 2};
    vecs[9]  = '{"orr_pc",   32'hE180F001, 1'b1, 4, 1, 2, 0, 0, 3};
    vecs[10] = '{"b",        32'hEA000002, 1'b1, 3, 0, 2, 0, 0, 0};
    vecs[11] = '{"b_nc",     32'hEA000002, 1'b0, 3, 0, 1, 0, 0, 0};
    vecs[12] = '{"op11",     32'hEC000000, 1'b1, 2, 0, 1, 0, 0, 0};
    vecs[13] = '{"cmn",      32'hE1700001, 1'b1, 4, 0, 1, 0, 3, 0};
    vecs[14] = '{"subs",     32'hE2521001, 1'b1, 4, 1, 1, 0, 3, 1};

    RESET = 1'b1; MemReady = 1'b0; Instr = 32'h0; CondEx = 1'b0;
    repeat (2) @(negedge CLK);
    MemReady = 1'b1;
    #1;
    chk("reset_state", State, 4'd0);
    chk("reset_irwrite", IRWrite, 1'b0);
    chk("reset_pcwrite", PCWrite, 1'b0);
    @(negedge CLK);
    RESET = 1'b0;
    MemReady = 1'b0;

    foreach (vecs[i]) begin
      exec_instr(vecs[i].instr, vecs[i].condex, 0);
      chk({vecs[i].name, "_cycles"}, st_q.size(), vecs[i].cycles);
      chk({vecs[i].name, "_regw"}, o_regw, vecs[i].regw);
      chk({vecs[i].name, "_pcw"}, o_pcw, vecs[i].pcw);
      chk({vecs[i].name, "_memw"}, o_memw, vecs[i].memw);
      chk({vecs[i].name, "_flagw"}, o_flag, vecs[i].flagw);
      chk({vecs[i].name, "_alu"}, o_alu, vecs[i].alu);
    end

    // LDR with two stalled cycles in MEMRD.
    hold3 = 2;
    exec_instr(32'hE5143008, 1'b1, 0);
    ldr_exp = '{0, 1, 2, 3, 3, 3, 4};
    chk("ldr_wait_len", st_q.size(), 7);
    foreach (ldr_exp[k]) chk($sformatf("ldr_wait_state[%0d]", k), (k < st_q.size()) ? st_q[k] : -1, ldr_exp[k]);
    chk("ldr_wait_alu", o_alu, 1);
    chk("ldr_wait_regw_cnt", o_regw, 1);
    chk("ldr_wait_regw_state", o_regw_st, 4);

    // Reset while a store waits in MEMWR.
    Instr = 32'hE5843000; CondEx = 1'b1;
    @(negedge CLK); MemReady = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK); MemReady = 1'b0;
    #1;
    chk("rst_pre_state", State, 4'd5);
    chk("rst_pre_memw", MemW, 1'b1);
    RESET = 1'b1;
    #1;
    chk("rst_memw_gated", MemW, 1'b0);
    @(negedge CLK); MemReady = 1'b1;
    #1;
    chk("rst_state_fetch", State, 4'd0);
    chk("rst_irwrite_gated", IRWrite, 1'b0);
    chk("rst_pcwrite_gated", PCWrite, 1'b0);
    @(negedge CLK); RESET = 1'b0; Instr = 32'hEC000000;
    #1;
    chk("rst_release_state", State, 4'd0);
    chk("rst_release_irwrite", IRWrite, 1'b1);
    @(posedge CLK); #1;
    chk("rst_to_decode", State, 4'd1);
    @(posedge CLK); #1;
    chk("op11_to_fetch", State, 4'd0);

    // Branch, then an illegal state code.
    exec_instr(32'hEA000002, 1'b1, 0);
    chk("b_imm_state9", o_imm, 2);
    chk("b_pcw", o_pcw, 2);
    @(negedge CLK); MemReady = 1'b0;
    force dut.state_q = 4'd12;
    #1;
    chk("illegal_forced", State, 4'd12);
    release dut.state_q;
    @(posedge CLK); #1;
    chk("illegal_to_fetch", State, 4'd0);

    cl = '{4'h0, 4'h2, 4'h4, 4'hC, 4'hA, 4'hB, 4'hD, 4'h1};
    for (int i = 0; i < 40; i++) begin
      ins = $urandom;
      ins[27:26] = 2'($urandom_range(0, 3));
      if (ins[27:26] == 2'b00) ins[24:21] = cl[$urandom_range(0, 7)];
      if ($urandom_range(0, 3) == 0) ins[15:12] = 4'hF;
      cx = 1'($urandom_range(0, 1));
      exec_instr(ins, cx, 1);
      check_model(ins, cx);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
